seq_add_sub: RTL and testbench
==============================

# seq_add_sub

Parametrised, multi-cycle ripple adder/subtractor for the calculator datapath. It replaces the single-bit combinational full-adder cell with a sequential engine. Each cycle it adds one DIGIT-bit slice of two WIDTH-bit operands, LSB slice first, through an internal DIGIT-bit ripple chain and a registered carry. A start/busy/done handshake connects it to the calculator controller. It also reports carry, signed overflow and zero flags.

## Interface
- WIDTH, default 8: operand and result width in bits; must be at least 2.
- DIGIT, default 1: bits processed per cycle.
  - Must divide WIDTH exactly.
  - Slice count NSLICE = WIDTH/DIGIT.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  request a new operation; sampled only in IDLE.
- i_sub  input  1  0 = A+B, 1 = A−B (two's complement); latched with i_start.
- i_A  input  WIDTH  operand A; latched with i_start.
- i_B  input  WIDTH  operand B; latched with i_start.
- o_busy  output  1  high while in RUN.
- o_done  output  1  one-cycle pulse; result and flags are valid from this cycle on.
- o_sum  output  WIDTH  result, held until the next completion.
- o_carry  output  1  carry out of the MSB; for subtraction, 1 = no borrow.
- o_overflow  output  1  signed overflow.
- o_zero  output  1  high when o_sum is 0.

## Operation
- Reset (i_reset high at an edge) puts the block in the following state:
  - state IDLE and slice counter 0.
  - o_busy=0, o_done=0.
  - o_sum=0, o_carry=0, o_overflow=0, o_zero=0.
  - Reset wins over every other input in the same cycle.
- States: IDLE and RUN.
- IDLE to RUN, when i_start=1 at an edge:
  - Latch A=i_A and B'=i_B XOR {WIDTH{i_sub}}.
  - Carry register = i_sub.
  - Counter = 0, o_busy=1.
- RUN, each edge:
  - Add slice[counter] of A and B' plus the carry register through the DIGIT-bit ripple chain.
  - Write the slice sum into the result shift/slice register.
  - Update the carry register with the slice carry-out.
  - Increment the counter.
- RUN on the last slice (counter = NSLICE−1):
  - Record the carry into the MSB, needed for overflow.
  - Commit the full result to o_sum.
  - o_carry = final carry.
  - o_overflow = carry-into-MSB XOR final carry.
  - o_zero = (result == 0).
  - o_done=1 for the next cycle, o_busy=0, return to IDLE.
- i_start while in RUN is ignored; no queueing.
- Operand or i_sub changes while in RUN have no effect, because operands are latched.
- Outputs o_sum and the flags change only at completion or reset. They are never partially updated during RUN.
- Arithmetic is modulo 2^WIDTH. The flags follow standard two's-complement rules for both add and subtract.

## Timing
- Start accepted at edge t0; o_busy is high from t0.
- Slices are processed at edges t0+1 … t0+NSLICE.
- o_done, o_sum and the flags update at edge t0+NSLICE.
  - Latency from the accept edge is NSLICE cycles.
  - Example: 8 cycles for WIDTH=8, DIGIT=1.
- o_done is high for exactly one cycle. o_busy falls at the same edge o_done rises.
- Back-to-back operation:
  - i_start high during the o_done cycle is accepted at the next edge, since the block is already in IDLE.
  - Maximum throughput is one operation per NSLICE+1 cycles.
- Reset asserted mid-RUN:
  - Aborts the operation and applies the reset values at that edge.
  - No o_done pulse; the result of the aborted operation is lost.
- Reset and i_start at the same edge: reset wins, and the block stays in IDLE.

## Test plan
- WIDTH=8, DIGIT=1; A=5, B=3, add, start at edge t0:
  - o_done pulses at t0+8 for one cycle.
  - o_sum=0x08, carry=0, overflow=0, zero=0.
  - o_busy is high t0..t0+7.
- A=0xFF, B=0x01, add → o_sum=0x00, carry=1, overflow=0, zero=1. Then A=0x7F, B=0x01, add → o_sum=0x80, carry=0, overflow=1.
- Subtract:
  - 3−5 → o_sum=0xFE, carry=0, overflow=0.
  - 0x80−0x01 → o_sum=0x7F, carry=1, overflow=1.
  - 7−7 → o_sum=0x00, carry=1, zero=1.
- WIDTH=16, DIGIT=4; A=0x1234, B=0x0FCC, add → o_done at t0+4, o_sum=0x2200, carry=0.
- WIDTH=8, DIGIT=1; handshake and reset boundaries:
  - Pulse i_start again at t0+3 with new operands → ignored; the result is still that of the first operation.
  - Reset at t0+4 → o_busy=0 immediately, no o_done, o_sum=0.
  - A new start in the o_done cycle completes 8 cycles after its accept edge.

Source files
------------

// File: rtl/seq_add_sub.sv
// Multi-cycle ripple adder/subtractor: one DIGIT-bit slice per cycle, LSB slice first,
// with a registered carry between slices and start/busy/done handshake.
module seq_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             finish;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res;
  logic             carry;

  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] b_sl;
  logic [DIGIT-1:0] sl_sum;
  logic             c_chain;
  logic             c_top;
  logic             c_out;
  logic [WIDTH-1:0] res_full;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_busy = (state == RUN);

  // Slice select by counter; constant part-selects keep the mux explicit.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) begin
        a_sl = a_reg[i*DIGIT +: DIGIT];
        b_sl = b_reg[i*DIGIT +: DIGIT];
      end
    end
  end

  // DIGIT-bit ripple chain; c_top is the carry into the slice MSB (the word MSB on the last slice).
  always_comb begin
    sl_sum  = '0;
    c_chain = carry;
    c_top   = 1'b0;
    for (int j = 0; j < DIGIT; j++) begin
      if (j == DIGIT - 1) c_top = c_chain;
      sl_sum[j] = a_sl[j] ^ b_sl[j] ^ c_chain;
      c_chain   = (a_sl[j] & b_sl[j]) | (c_chain & (a_sl[j] ^ b_sl[j]));
    end
    c_out = c_chain;
  end

  always_comb begin
    res_full = res;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) res_full[i*DIGIT +: DIGIT] = sl_sum;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      res        <= '0;
      carry      <= 1'b0;
      o_done     <= 1'b0;
      o_sum      <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      o_zero     <= 1'b0;
    end else begin
      o_done <= finish;
      if (load) begin
        a_reg <= i_A;
        b_reg <= i_B ^ {WIDTH{i_sub}};
        carry <= i_sub;
        cnt   <= '0;
        res   <= '0;
      end
      if (step) begin
        res   <= res_full;
        carry <= c_out;
        cnt   <= cnt + 1'b1;
      end
      if (finish) begin
        cnt        <= '0;
        o_sum      <= res_full;
        o_carry    <= c_out;
        o_overflow <= c_top ^ c_out;
        o_zero     <= (res_full == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench for seq_add_sub: 8-bit/1-digit and 16-bit/4-digit instances,
// expected results from a signed/unsigned arithmetic model, checked by per-instance monitors.
module tb_seq_add_sub;

  typedef struct {
    logic [15:0] sum;
    bit          carry;
    bit          ovf;
    bit          zero;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic       rst8 = 1'b1, start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, carry8, ovf8, zero8;

  logic        rst16 = 1'b1, start16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        busy16, done16, carry16, ovf16, zero16;

  exp_t        q8[$];
  exp_t        q16[$];
  logic [15:0] held8 = '0;
  logic [15:0] held16 = '0;

  seq_add_sub #(.WIDTH(8), .DIGIT(1)) u8 (
    .i_clk(clk), .i_reset(rst8), .i_start(start8), .i_sub(sub8), .i_A(a8), .i_B(b8),
    .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_carry(carry8),
    .o_overflow(ovf8), .o_zero(zero8)
  );

  seq_add_sub #(.WIDTH(16), .DIGIT(4)) u16 (
    .i_clk(clk), .i_reset(rst16), .i_start(start16), .i_sub(sub16), .i_A(a16), .i_B(b16),
    .o_busy(busy16), .o_done(done16), .o_sum(sum16), .o_carry(carry16),
    .o_overflow(ovf16), .o_zero(zero16)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: unsigned arithmetic for sum/carry, signed range test for overflow.
  function automatic exp_t model(input int w, input int a, input int b, input bit sub,
                                 input int due);
    exp_t e;
    int m, sa, sb, sr, full;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (sub) begin
      full    = a - b;
      sr      = sa - sb;
      e.carry = (a >= b);
    end else begin
      full    = a + b;
      sr      = sa + sb;
      e.carry = (full >= m);
    end
    e.sum  = 16'(((full % m) + m) % m);
    e.ovf  = (sr < -(m / 2)) || (sr >= m / 2);
    e.zero = (e.sum == 16'd0);
    e.due  = due;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst8) begin
      if (done8) begin
        chk("busy_low_at_done8", busy8, 0);
        if (q8.size() == 0) chk("spurious_done8", done8, 0);
        else begin
          e = q8.pop_front();
          chk("sum8", sum8, e.sum);
          chk("carry8", carry8, e.carry);
          chk("ovf8", ovf8, e.ovf);
          chk("zero8", zero8, e.zero);
          chk("latency8", cyc, e.due);
          held8 = e.sum;
        end
      end else if (busy8) begin
        chk("sum_held8", sum8, held8);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst16) begin
      if (done16) begin
        chk("busy_low_at_done16", busy16, 0);
        if (q16.size() == 0) chk("spurious_done16", done16, 0);
        else begin
          e = q16.pop_front();
          chk("sum16", sum16, e.sum);
          chk("carry16", carry16, e.carry);
          chk("ovf16", ovf16, e.ovf);
          chk("zero16", zero16, e.zero);
          chk("latency16", cyc, e.due);
          held16 = e.sum;
        end
      end else if (busy16) begin
        chk("sum_held16", sum16, held16);
      end
    end
  end

  // All driver tasks start and end just after a falling edge.
  task automatic issue8(input int a, input int b, input bit sub);
    int guard = 0;
    while (busy8 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("idle_wait8", busy8, 0);
    start8 = 1'b1; a8 = 8'(a); b8 = 8'(b); sub8 = sub;
    q8.push_back(model(8, a, b, sub, cyc + 1 + 8));
    @(negedge clk);
    start8 = 1'b0;
    chk("busy_after_start8", busy8, 1);
  endtask

  task automatic issue16(input int a, input int b, input bit sub);
    int guard = 0;
    while (busy16 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("idle_wait16", busy16, 0);
    start16 = 1'b1; a16 = 16'(a); b16 = 16'(b); sub16 = sub;
    q16.push_back(model(16, a, b, sub, cyc + 1 + 4));
    @(negedge clk);
    start16 = 1'b0;
    chk("busy_after_start16", busy16, 1);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q8.size() != 0 || q16.size() != 0 || busy8 || busy16) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", q8.size() + q16.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_flags8", {carry8, ovf8, zero8}, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_sum16", sum16, 0);
    rst8 = 1'b0; rst16 = 1'b0;
    @(negedge clk);

    issue8(5, 3, 0);
    drain();
    issue8(8'hFF, 8'h01, 0);
    issue8(8'h7F, 8'h01, 0);
    issue8(3, 5, 1);
    issue8(8'h80, 8'h01, 1);
    issue8(7, 7, 1);
    drain();
    issue16(16'h1234, 16'h0FCC, 0);
    issue16(16'hFFFF, 16'h0001, 0);
    issue16(16'h8000, 16'h0001, 1);
    drain();

    // Second start mid-run with different operands must be ignored.
    issue8(8'h21, 8'h42, 0);
    @(negedge clk);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain();

    // Reset four edges after accept aborts the operation.
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1; held8 = '0;
    @(negedge clk);
    chk("abort_busy8", busy8, 0);
    chk("abort_done8", done8, 0);
    chk("abort_sum8", sum8, 0);
    chk("abort_flags8", {carry8, ovf8, zero8}, 0);
    rst8 = 1'b0;
    repeat (12) @(negedge clk);

    // Reset and start together: reset wins.
    issue8(8'h40, 8'h40, 0);
    drain();
    rst8 = 1'b1; start8 = 1'b1; held8 = '0;
    @(negedge clk);
    rst8 = 1'b0; start8 = 1'b0;
    @(negedge clk);
    chk("rst_and_start_busy8", busy8, 0);
    chk("rst_and_start_sum8", sum8, 0);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 40; i++)
      issue8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++)
      issue16(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
